// File: rtl/mul_div_iter_if.sv
// Request/response bundle for the iterative multiplier/divider.
// The master drives the request; the slave (the unit) returns the result.
interface mul_div_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic [1:0]           op_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 div_zero_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, busy_o, div_zero_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, busy_o, div_zero_o
    );
endinterface

// File: rtl/mul_div_iter.sv
// Radix-2 iterative signed/unsigned multiplier and restoring divider.
// Works on operand magnitudes and applies the result signs once, in FIN.
module mul_div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    mul_div_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dz_pend;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_op1;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_ready;
    logic                 r_div_zero;

    logic                 w_accept;
    logic                 w_div_zero_in;
    logic                 w_signed;
    logic                 w_s1;
    logic                 w_s2;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_ext;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_diff;
    logic [2*WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [2*WIDTH-1:0]   w_fin;

    assign w_accept      = (r_state == IDLE) && bus.start_i && !bus.annul_i;
    assign w_div_zero_in = bus.op_i[1] && (bus.opdata2_i == '0);
    assign w_signed      = ~bus.op_i[0];
    assign w_s1          = w_signed & bus.opdata1_i[WIDTH-1];
    assign w_s2          = w_signed & bus.opdata2_i[WIDTH-1];
    assign w_mag1        = w_s1 ? -bus.opdata1_i : bus.opdata1_i;
    assign w_mag2        = w_s2 ? -bus.opdata2_i : bus.opdata2_i;

    // MUL: {hi, multiplier} shifts right, multiplicand added into hi on LSB=1.
    // DIV: {partial remainder, dividend/quotient} shifts left, quotient bit enters at LSB.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_div_ext  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ge   = w_div_ext >= {1'b0, r_b};
    assign w_div_diff = w_div_ext[WIDTH-1:0] - r_b;
    assign w_step     = r_is_div
                      ? {(w_div_ge ? w_div_diff : w_div_ext[WIDTH-1:0]), r_acc[WIDTH-2:0], w_div_ge}
                      : {w_mul_sum, r_acc[WIDTH-1:1]};

    assign w_quot = r_acc[WIDTH-1:0];
    assign w_rem  = r_acc[2*WIDTH-1:WIDTH];

    // The most-negative / -1 case needs no special handling: the magnitude
    // quotient 2^(WIDTH-1) negates back onto itself with a zero remainder.
    always_comb begin
        w_fin = r_neg_q ? -r_acc : r_acc;
        if (r_dz_pend) begin
            w_fin = {r_op1, {WIDTH{1'b1}}};
        end else if (r_is_div) begin
            w_fin = {(r_neg_r ? -w_rem : w_rem), (r_neg_q ? -w_quot : w_quot)};
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_next = w_div_zero_in ? FIN : CALC;
            CALC: begin
                if (bus.annul_i)                          w_state_next = IDLE;
                else if (r_cnt == CNT_W'(WIDTH - 1))      w_state_next = FIN;
            end
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_result   <= '0;
            r_ready    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_ready    <= 1'b0;
            r_div_zero <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_div  <= bus.op_i[1];
                        r_neg_q   <= w_s1 ^ w_s2;
                        r_neg_r   <= w_s1;
                        r_dz_pend <= w_div_zero_in;
                        r_a       <= w_mag1;
                        r_b       <= w_mag2;
                        r_op1     <= bus.opdata1_i;
                        r_acc     <= {{WIDTH{1'b0}}, (bus.op_i[1] ? w_mag1 : w_mag2)};
                        r_cnt     <= '0;
                    end
                end
                CALC: begin
                    if (!bus.annul_i) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FIN: begin
                    if (!bus.annul_i) begin
                        r_result   <= w_fin;
                        r_ready    <= 1'b1;
                        r_div_zero <= r_dz_pend;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_o   = r_result;
    assign bus.ready_o    = r_ready;
    assign bus.div_zero_o = r_div_zero;
    assign bus.busy_o     = (r_state != IDLE);
endmodule

// File: tb/tb_mul_div_iter.sv
// Self-checking bench: directed corner cases plus randomized operations
// against an arithmetic reference model, on a 32-bit and an 8-bit instance.
module tb_mul_div_iter;
    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic rst8 = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [63:0] last_res = '0;

    always #5 clk = ~clk;

    mul_div_iter_if #(.WIDTH(32)) bus  ();
    mul_div_iter_if #(.WIDTH(8))  bus8 ();

    mul_div_iter #(.WIDTH(32), .CNT_W(6)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    mul_div_iter #(.WIDTH(8),  .CNT_W(4)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain integer arithmetic: sign-extend, multiply/divide, pack {rem, quot}.
    function automatic logic [63:0] ref_model(input int w, input logic [1:0] op,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, ua, ub, p, q, r;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        ua = a & mask;
        ub = b & mask;
        sa = $signed(ua << (64 - w)) >>> (64 - w);
        sb = $signed(ub << (64 - w)) >>> (64 - w);
        if (op[1]) begin
            if (ub == 0) return (ua << w) | mask;
            if (op == 2'd2) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
            return ((r & mask) << w) | (q & mask);
        end
        p = (op == 2'd0) ? 64'(sa * sb) : ua * ub;
        if (w == 32) return p;
        return p & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h80;
            default: return v[7:0];
        endcase
    endfunction

    // Issue one operation; operands and start are scrambled while busy.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
        int lat, c;
        logic dz;
        dz  = op[1] && (b == 0);
        lat = dz ? 1 : 33;
        bus.start_i = 1'b1; bus.op_i = op; bus.opdata1_i = a; bus.opdata2_i = b; bus.annul_i = 1'b0;
        tick();
        chk({tag, "_ready_pulse"}, 64'(bus.ready_o), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
        for (c = 1; c <= lat + 4; c++) begin
            bus.start_i   = 1'($urandom_range(0, 1));
            bus.op_i      = 2'($urandom_range(0, 3));
            bus.opdata1_i = $urandom;
            bus.opdata2_i = $urandom;
            tick();
            if (bus.ready_o) break;
        end
        bus.start_i = 1'b0;
        chk({tag, "_latency"}, 64'(c), 64'(lat));
        chk({tag, "_result"}, bus.result_o, exp);
        chk({tag, "_div_zero"}, 64'(bus.div_zero_o), 64'(dz));
        $display("[TB] %s op=%0d a=%h b=%h result=%h lat=%0d", tag, op, a, b, bus.result_o, c);
        last_res = exp;
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string tag);
        int lat, c;
        logic dz;
        dz  = op[1] && (b == 0);
        lat = dz ? 1 : 9;
        bus8.start_i = 1'b1; bus8.op_i = op; bus8.opdata1_i = a; bus8.opdata2_i = b; bus8.annul_i = 1'b0;
        tick();
        bus8.start_i = 1'b0;
        bus8.opdata1_i = 8'($urandom);
        bus8.opdata2_i = 8'($urandom);
        for (c = 1; c <= lat + 4; c++) begin
            tick();
            if (bus8.ready_o) break;
        end
        chk({tag, "_latency"}, 64'(c), 64'(lat));
        chk({tag, "_result"}, 64'(bus8.result_o), 64'(exp));
        chk({tag, "_div_zero"}, 64'(bus8.div_zero_o), 64'(dz));
        $display("[TB] %s op=%0d a=%h b=%h result=%h lat=%0d", tag, op, a, b, bus8.result_o, c);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [7:0]  a8, b8;
        logic [1:0]  op;
        logic        saw;

        bus.start_i = 0;  bus.op_i = 0;  bus.opdata1_i = 0;  bus.opdata2_i = 0;  bus.annul_i = 0;
        bus8.start_i = 0; bus8.op_i = 0; bus8.opdata1_i = 0; bus8.opdata2_i = 0; bus8.annul_i = 0;
        bus.start_i = 1'b1;
        repeat (3) tick();
        bus.start_i = 1'b0;
        chk("rst_result", bus.result_o, 64'd0);
        chk("rst_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_div_zero", 64'(bus.div_zero_o), 64'd0);
        rst = 1'b1; rst8 = 1'b1;
        tick();

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, "mul_neg3x7");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "mulu_max");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, "div_neg7by2");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_overflow");
        run_op(2'd3, 32'd5, 32'd0,                64'h0000_0005_FFFF_FFFF, "divu_5by0");
        run_op(2'd2, 32'h8000_0000, 32'd0,        64'h8000_0000_FFFF_FFFF, "div_min_by0");

        // Annul in CALC cycle 10 with start held: next IDLE cycle accepts again.
        bus.start_i = 1'b1; bus.op_i = 2'd0; bus.opdata1_i = 32'd1234; bus.opdata2_i = 32'd99; bus.annul_i = 1'b0;
        tick();
        saw = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            saw |= bus.ready_o;
        end
        bus.annul_i = 1'b1;
        tick();
        saw |= bus.ready_o;
        chk("annul_calc_no_ready", 64'(saw), 64'd0);
        chk("annul_calc_busy", 64'(bus.busy_o), 64'd0);
        chk("annul_calc_hold", bus.result_o, last_res);
        bus.annul_i = 1'b0;
        run_op(2'd1, 32'd77, 32'd1000, ref_model(32, 2'd1, 64'd77, 64'd1000), "after_annul");

        // Annul while in FIN (divide-by-zero path) suppresses ready and keeps result.
        bus.start_i = 1'b1; bus.op_i = 2'd3; bus.opdata1_i = 32'd42; bus.opdata2_i = 32'd0;
        tick();
        bus.start_i = 1'b0; bus.annul_i = 1'b1;
        tick();
        bus.annul_i = 1'b0;
        chk("annul_fin_ready", 64'(bus.ready_o), 64'd0);
        chk("annul_fin_div_zero", 64'(bus.div_zero_o), 64'd0);
        chk("annul_fin_hold", bus.result_o, last_res);
        tick();
        chk("annul_fin_ready_late", 64'(bus.ready_o), 64'd0);

        // Annul and start together in IDLE: no accept.
        bus.start_i = 1'b1; bus.annul_i = 1'b1;
        tick();
        bus.start_i = 1'b0; bus.annul_i = 1'b0;
        chk("annul_start_idle", 64'(bus.busy_o), 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick32();
            b  = pick32();
            run_op(op, a, b, ref_model(32, op, 64'(a), 64'(b)), $sformatf("rnd%0d", i));
        end

        run8(2'd2, 8'h80, 8'd3, 16'hFED6, "w8_div_neg128by3");
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            a8 = pick8();
            b8 = pick8();
            run8(op, a8, b8, 16'(ref_model(8, op, 64'(a8), 64'(b8))), $sformatf("w8_rnd%0d", i));
        end

        // Reset mid-CALC on the 8-bit unit.
        bus8.start_i = 1'b1; bus8.op_i = 2'd0; bus8.opdata1_i = 8'd13; bus8.opdata2_i = 8'd11;
        tick();
        bus8.start_i = 1'b0;
        repeat (3) tick();
        rst8 = 1'b0;
        tick();
        chk("w8_rst_result", 64'(bus8.result_o), 64'd0);
        chk("w8_rst_ready", 64'(bus8.ready_o), 64'd0);
        chk("w8_rst_busy", 64'(bus8.busy_o), 64'd0);
        chk("w8_rst_div_zero", 64'(bus8.div_zero_o), 64'd0);
        rst8 = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            saw |= bus8.ready_o;
        end
        chk("w8_rst_no_ready", 64'(saw), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_div_iter.md
MUL_DIV_ITER -- requirements
Module: mul_div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal 8..64, even).
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start_i  input  1  request; sampled only in IDLE.
REQ-006 op_i  input  2  00 MUL signed, 01 MULU unsigned, 10 DIV signed, 11 DIVU unsigned.
REQ-007 opdata1_i  input  WIDTH  multiplicand / dividend.
REQ-008 opdata2_i  input  WIDTH  multiplier / divisor.
REQ-009 annul_i  input  1  abort the current operation.
REQ-010 result_o  output  2*WIDTH  MUL: full product; DIV: {remainder, quotient}.
REQ-011 ready_o  output  1  one-cycle pulse, result_o valid.
REQ-012 busy_o  output  1  high in CALC and FIN.
REQ-013 div_zero_o  output  1  set with ready_o when a DIV/DIVU had divisor 0.

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIN; reset state IDLE.
REQ-015 IDLE, start_i=1, annul_i=0: latch op_i, operand magnitudes (signed ops: two's-complement abs), result signs; counter=0; go to CALC.
REQ-016 DIV/DIVU with opdata2_i=0 at accept: SHALL go directly to FIN, skipping CALC.
REQ-017 CALC SHALL perform exactly one radix-2 step per cycle: MUL shift-add on LSB of multiplier, DIV restoring shift-subtract of a 2*WIDTH remainder/quotient register.
REQ-018 After WIDTH CALC cycles (counter = WIDTH-1 at the edge), SHALL go to FIN.
REQ-019 FIN, one cycle: register result_o, ready_o=1, div_zero_o as applicable; next state IDLE.
REQ-020 Latency: accept at edge T0 -> ready_o high after edge T0+WIDTH+1; divide-by-zero -> after edge T0+1.
REQ-021 MUL sign: negate the 2*WIDTH product when operand signs differ; MULU never negates.
REQ-022 DIV sign: quotient negative when signs differ; remainder takes dividend sign; DIVU never negates.
REQ-023 Signed overflow (most-negative / -1) SHALL yield quotient = most-negative, remainder = 0, div_zero_o=0.
REQ-024 Divide-by-zero SHALL yield quotient all ones, remainder = opdata1_i unmodified, div_zero_o=1.
REQ-025 ready_o and div_zero_o SHALL be low in every cycle except the FIN output cycle.
REQ-026 result_o SHALL hold its value until the next FIN; SHALL NOT change on accept or annul.
REQ-027 start_i while busy_o=1 SHALL be ignored; no queueing.
REQ-028 annul_i=1 in CALC or FIN SHALL return to IDLE at that edge, no ready_o pulse, result_o unchanged.
REQ-029 annul_i=1 with start_i=1 in IDLE: annul wins, no accept.
REQ-030 Operand inputs SHALL be don't-care after accept; internal copies used.
REQ-031 Back-to-back: start_i sampled in the IDLE cycle immediately after FIN SHALL be accepted.

Reset
REQ-032 rst=0 at an edge SHALL force IDLE, counter=0, result_o=0, ready_o=0, busy_o=0, div_zero_o=0, regardless of state.
REQ-033 Reset mid-CALC SHALL discard the operation; no ready_o pulse after reset release.
REQ-034 Reset SHALL take priority over start_i and annul_i.

Verification (WIDTH=32 unless stated)
REQ-035 MUL -3 x 7 -> ready_o 33 cycles after accept, result_o=0xFFFFFFFF_FFFFFFEB, div_zero_o=0.
REQ-036 MULU 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0xFFFFFFFE_00000001.
REQ-037 DIV -7 / 2 -> result_o=0xFFFFFFFF_FFFFFFFD; DIV 0x80000000 / -1 -> 0x00000000_80000000.
REQ-038 DIVU 5 / 0 -> ready_o 1 cycle after accept, result_o=0x00000005_FFFFFFFF, div_zero_o=1.
REQ-039 Accept MUL, annul_i at CALC cycle 10, start_i held -> no ready_o, result_o holds prior value, new accept on the following IDLE cycle.
REQ-040 WIDTH=8: DIV -128 / 3 -> ready_o after 9 cycles, result_o=0xFE_D6; rst=0 mid-CALC -> all outputs 0, no ready_o.
